// File: rtl/dataflow_decoder.sv
// Two-stage decoder for the incrementing/conditional-shift byte code.
// Define DFD_ERR_CNT_EN to build the saturating error counter.
module dataflow_decoder #(
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] THRESH = DATA_W'('h10),
  parameter int                CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W:0]   in_code,
  input  logic              in_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt
);

  logic              s1_v;
  logic              s1_sh;
  logic              s1_err;
  logic [DATA_W-1:0] s1_u;

  logic              s1_ld;
  logic              s2_ld;
  logic [DATA_W-1:0] u_c;
  logic              e_c;
  logic [DATA_W-1:0] orig;
  logic              rng_err;

  assign s2_ld    = !out_valid || out_ready;
  assign s1_ld    = !s1_v || s2_ld;
  assign in_ready = s1_ld;

  always_comb begin
    u_c = in_code[DATA_W-1:0];
    e_c = in_code[DATA_W];
    if (in_shift) begin
      u_c = in_code[DATA_W:1];
      e_c = in_code[0];
    end
  end

  // u=0 wraps to all-ones, which is a legal encoding
  always_comb begin
    orig    = s1_u - DATA_W'(1);
    rng_err = s1_sh ? (orig <= THRESH) : (orig > THRESH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_sh  <= 1'b0;
      s1_err <= 1'b0;
      s1_u   <= '0;
    end else if (s1_ld) begin
      s1_v   <= in_valid;
      s1_sh  <= in_shift;
      s1_err <= e_c;
      s1_u   <= u_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (s2_ld) begin
      out_valid <= s1_v;
      out_data  <= orig;
      out_err   <= s1_err | rng_err;
    end
  end

`ifdef DFD_ERR_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (out_valid && out_ready && out_err && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign err_cnt = cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_dataflow_decoder.sv
// Scoreboard bench for dataflow_decoder.
// Expected err_cnt follows DFD_ERR_CNT_EN.
module tb_dataflow_decoder;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW:0]   in_code = '0;
  logic          in_shift = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_err;
  logic [CW-1:0] err_cnt;

  int tests = 0;
  int fails = 0;
  int nerr = 0;
  logic [DW:0] sb[$];

  logic [DW:0] vc[9] = '{9'h042, 9'h122, 9'h006, 9'h011, 9'h000,
                         9'h022, 9'h043, 9'h121, 9'h030};
  logic        vs[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                         1'b1, 1'b1, 1'b0, 1'b0};
  logic [DW:0] ve[9] = '{9'h020, 9'h090, 9'h005, 9'h010, 9'h0FF,
                         9'h110, 9'h120, 9'h120, 9'h12F};

  always #5 clk = ~clk;

  dataflow_decoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .in_shift (in_shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .err_cnt  (err_cnt)
  );

  function automatic logic [DW:0] model(logic [DW:0] c, logic s);
    logic [DW-1:0] u;
    logic [DW-1:0] o;
    logic          e;
    u = s ? c[DW:1] : c[DW-1:0];
    e = s ? c[0] : c[DW];
    o = u - 8'd1;
    if (s) e = e | (o <= 8'h10);
    else   e = e | (o > 8'h10);
    return {e, o};
  endfunction

  function automatic logic [CW-1:0] exp_cnt();
`ifdef DFD_ERR_CNT_EN
    return CW'(nerr > 255 ? 255 : nerr);
`else
    return '0;
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_code = 9'h0AA;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({out_valid, out_err, out_data} !== 10'h0) begin
      fails++;
      $display("FAIL reset_out: got v=%b e=%b d=%h, expected 0 0 00",
               out_valid, out_err, out_data);
    end
    tests++;
    if (in_ready !== 1'b1 || err_cnt !== '0) begin
      fails++;
      $display("FAIL reset_rdy: got rdy=%b cnt=%0d, expected 1 0",
               in_ready, err_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_code = 9'h042;
    in_shift = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL lat_accept: got rdy=%b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL lat_early: got out_valid=%b, expected 0", out_valid);
    end
    @(negedge clk);
    tests++;
    if ({out_valid, out_err, out_data} !== 10'h220) begin
      fails++;
      $display("FAIL lat_out: got v=%b e=%b d=%h, expected 1 0 20",
               out_valid, out_err, out_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_vectors();
    int i = 0;
    int cyc = 0;
    logic [DW:0] exp;
    out_ready = 1'b1;
    while ((i < 9 || sb.size() > 0 || out_valid) && cyc < 100) begin
      in_valid = (i < 9);
      if (i < 9) begin
        in_code = vc[i];
        in_shift = vs[i];
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL vec_extra: got %h, expected no output",
                   {out_err, out_data});
        end else begin
          exp = sb.pop_front();
          if (exp[DW]) nerr++;
          if ({out_err, out_data} !== exp) begin
            fails++;
            $display("FAIL vec_data: got %h, expected %h",
                     {out_err, out_data}, exp);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(ve[i]);
        i++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    tests++;
    if (cyc >= 100) begin
      fails++;
      $display("FAIL vec_timeout: got %0d left, expected 0", sb.size());
    end
  endtask

  task automatic test_errcnt();
    @(negedge clk);
    tests++;
    if (err_cnt !== exp_cnt()) begin
      fails++;
      $display("FAIL err_cnt: got %0d, expected %0d", err_cnt, exp_cnt());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int i = 0;
    int cyc = 0;
    logic [DW:0] exp;
    logic [DW:0] held = '0;
    logic        held_v = 1'b0;
    logic [DW:0] c;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      c = {1'b0, 8'(8'h30 + i)} << 1;
      in_valid = (i < 8);
      in_code = c;
      in_shift = 1'b1;
      @(negedge clk);
      if (out_valid) begin
        if (held_v) begin
          tests++;
          if ({out_err, out_data} !== held) begin
            fails++;
            $display("FAIL bp_hold: got %h, expected %h",
                     {out_err, out_data}, held);
          end
        end
        held = {out_err, out_data};
        held_v = 1'b1;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(c, 1'b1));
        i++;
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if (i !== 2 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_accepts: got %0d rdy=%b, expected 2 0", i, in_ready);
    end
    out_ready = 1'b1;
    while ((i < 8 || sb.size() > 0 || out_valid) && cyc < 100) begin
      c = {1'b0, 8'(8'h30 + i)} << 1;
      in_valid = (i < 8);
      in_code = c;
      in_shift = 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL bp_extra: got %h, expected no output",
                   {out_err, out_data});
        end else begin
          exp = sb.pop_front();
          if (exp[DW]) nerr++;
          if ({out_err, out_data} !== exp) begin
            fails++;
            $display("FAIL bp_order: got %h, expected %h",
                     {out_err, out_data}, exp);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(c, 1'b1));
        i++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    tests++;
    if (cyc >= 100 || i != 8) begin
      fails++;
      $display("FAIL bp_timeout: got %0d sent, expected 8", i);
    end
  endtask

  task automatic test_back_to_back();
    int i = 0;
    int cyc = 0;
    logic [DW:0] exp;
    logic [DW:0] c;
    logic        s;
    while ((i < 60 || sb.size() > 0 || out_valid) && cyc < 1000) begin
      c = 9'($urandom);
      s = 1'($urandom);
      in_valid = (i < 60) && ($urandom_range(0, 9) < 8);
      in_code = c;
      in_shift = s;
      out_ready = (cyc < 40) ? 1'b1 : ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (out_valid && out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL b2b_extra: got %h, expected no output",
                   {out_err, out_data});
        end else begin
          exp = sb.pop_front();
          if (exp[DW]) nerr++;
          if ({out_err, out_data} !== exp) begin
            fails++;
            $display("FAIL b2b_data: got %h, expected %h",
                     {out_err, out_data}, exp);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(c, s));
        i++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (cyc >= 1000) begin
      fails++;
      $display("FAIL b2b_timeout: got %0d left, expected 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_code = 9'h042;
    in_shift = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL rst_full: got rdy=%b v=%b, expected 0 1",
               in_ready, out_valid);
    end
    rst_n = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    nerr = 0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      fails++;
      $display("FAIL rst_mid: got v=%b rdy=%b d=%h, expected 0 1 00",
               out_valid, in_ready, out_data);
    end
    tests++;
    if (err_cnt !== '0) begin
      fails++;
      $display("FAIL rst_cnt: got %0d, expected 0", err_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL rst_stale: got out_valid=%b, expected 0", out_valid);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_errcnt();
    test_backpressure();
    test_back_to_back();
    test_errcnt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
